// File: rtl/filter_inverse.sv
// Streaming inverse of a monic integer FIR: recovers x from y = x + sum h_k*x[n-k].
// One registered output stage with a valid/ready handshake; the decode is a single-cycle MAC.
module filter_inverse #(
    parameter int DATA_WIDTH = 8,
    parameter int TAPS = 4,
    parameter logic [(TAPS-1)*DATA_WIDTH-1:0] COEFFS = 24'h010101
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] y_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] x_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [15:0]           sample_cnt
);

    localparam int HIST = TAPS - 1;

    logic [DATA_WIDTH-1:0] x_hist [1:HIST];
    logic [DATA_WIDTH-1:0] x_new;
    logic                  accept;

    assign in_ready = ~RST & ~clr & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;

    // h_k sits at bits [k*DATA_WIDTH-1 -: DATA_WIDTH]; products and the sum wrap mod 2^DATA_WIDTH.
    always_comb begin
        x_new = y_in;
        for (int k = 1; k <= HIST; k++) begin
            x_new = x_new - DATA_WIDTH'(COEFFS[k*DATA_WIDTH-1 -: DATA_WIDTH] * x_hist[k]);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 1; k <= HIST; k++) x_hist[k] <= '0;
            x_out      <= '0;
            out_valid  <= 1'b0;
            sample_cnt <= '0;
        end else if (clr) begin
            // x_out keeps its last value; only the pending valid is dropped.
            for (int k = 1; k <= HIST; k++) x_hist[k] <= '0;
            out_valid  <= 1'b0;
            sample_cnt <= '0;
        end else if (accept) begin
            x_out     <= x_new;
            out_valid <= 1'b1;
            x_hist[1] <= x_new;
            for (int k = 2; k <= HIST; k++) x_hist[k] <= x_hist[k-1];
            sample_cnt <= sample_cnt + 16'd1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/filter_inverse.md
Name: filter_inverse

Overview:
- Streaming inverse (deconvolution) stage for the team's integer FIR `Filter`.
- Recovers the original sample stream x from a filtered stream y, where y[n] = x[n] + sum_{k=1..TAPS-1} h_k*x[n-k] mod 2^DATA_WIDTH. The FIR is monic (h0 = 1), so the inverse is exact.
- Sits at the receive end of the filtered link and feeds downstream consumers through a valid/ready handshake.

Parameters:
- DATA_WIDTH, 8, sample and coefficient width; all arithmetic is mod 2^DATA_WIDTH.
- TAPS, 4, FIR length including h0; legal range 2..8.
- COEFFS, {8'h01,8'h01,8'h01}, packed h_{TAPS-1}..h_1 (MSB = highest tap), (TAPS-1)*DATA_WIDTH bits. Default inverts a 4-point running sum.

Ports:
- CLK, input, 1, single clock; all state updates on the rising edge.
- RST, input, 1, synchronous, active-high reset.
- clr, input, 1, synchronous flush of history and output register.
- y_in, input, DATA_WIDTH, filtered sample.
- in_valid, input, 1, y_in is valid.
- in_ready, output, 1, block accepts y_in this cycle.
- x_out, output, DATA_WIDTH, recovered sample.
- out_valid, output, 1, x_out is valid.
- out_ready, input, 1, downstream accepts x_out.
- sample_cnt, output, 16, count of accepted input samples; wraps at 2^16.

Behaviour:
- Reset (RST=1 at an edge) clears:
  - history x_hist[1..TAPS-1], x_out and sample_cnt to 0;
  - out_valid to 0.
- in_ready is 0 in any cycle where RST or clr is high.
- Priority at an edge: RST > clr > normal operation.
- in_ready = ~out_valid | out_ready (combinational) when RST=0 and clr=0.
- accept = in_valid & in_ready.
- On accept:
  - x_new = (y_in - sum_{k=1..TAPS-1} h_k*x_hist[k]) mod 2^DATA_WIDTH. Each product is truncated to DATA_WIDTH, and the accumulation wraps.
  - x_out <= x_new; out_valid <= 1.
  - History shifts: x_hist[1] <= x_new, x_hist[k] <= x_hist[k-1].
  - sample_cnt increments, wrapping 16'hFFFF -> 0.
- Latency is one cycle: x_out is valid on the edge after acceptance. Throughput is one sample per cycle while out_ready=1.
- If out_valid & out_ready and there is no accept: out_valid <= 0, and x_out holds its last value.
- Simultaneous drain and accept: out_valid stays 1 and x_out takes the new sample. No bubble and no loss.
- Backpressure (out_valid=1, out_ready=0):
  - in_ready=0.
  - x_out, out_valid, history and sample_cnt are all frozen.
  - in_valid and y_in are ignored; the upstream must hold them.
- History changes only on accept. Never on stall, clr-blocked or invalid cycles.
- clr:
  - History is zeroed and out_valid <= 0. A pending output is dropped.
  - sample_cnt is zeroed and x_out holds its value.
  - The next accepted sample is decoded as if all prior x were 0.
- Mid-stream reset behaves identically to clr, and additionally zeroes x_out.
- out_valid never deasserts without out_ready, except on RST or clr.
- The datapath is combinational MAC into the output register; there is no multi-cycle state machine. The handshake register is the only pipeline stage.

Test Plan:
- Default coefficients:
  - Stimulus: after reset, stream y = 01,03,06,0A,0E with out_ready=1.
  - Response: x_out = 01,02,03,04,05 on consecutive cycles, each one cycle after its accept; sample_cnt = 5.
- Wrap-around, default coefficients:
  - Stimulus: y = FF,FE,FD,FC.
  - Response: x_out = FF,FF,FF,FF. Exercises mod-256 subtraction and product truncation.
- Backpressure:
  - Stimulus: send y=01, then hold out_ready=0 for 3 cycles while presenting in_valid=1, y=03.
  - Required: x_out stays 01, out_valid=1 and in_ready=0 throughout.
  - Then release out_ready: 03 is accepted and x_out=02 on the next cycle.
- Flush and reset mid-stream:
  - Stimulus: accept 01,03 (giving x=01,02), then pulse clr for one cycle, then send y=05.
  - Required: out_valid=0 after clr, then x_out=05 and sample_cnt=1.
  - Repeat the sequence with RST in place of clr: same result, and x_out reads 00 during reset.
- Parameter variant (TAPS=2, COEFFS=8'hFF, i.e. h1=-1, a differencer):
  - Stimulus: y = 05,03,FE.
  - Response: x_out = 05,08,06 (accumulator behaviour, FE adds -2 mod 256).
- Continuous throughput:
  - Stimulus: 100 back-to-back samples, out_ready=1 and in_valid=1 every cycle, inputs generated by a reference FIR model.
  - Required: in_ready stays 1, 100 outputs arrive matching the original x sequence exactly, and sample_cnt=100.
